mem_port_arbiter: RTL and testbench

- Shares the single-port data RAM (ramD) between two requesters.
- Port 0 is the pipeline MEM stage. Port 1 is a secondary master (program loader / debug).
- Sequences synchronous-RAM read latency and returns read data with a valid pulse.
- Drives a stall to the pipeline while the MEM stage waits for the RAM; bounds port-1 starvation.

---
 rtl/mem_arb_pkg.sv | 11 +
 rtl/mem_arb_select.sv | 26 ++
 rtl/mem_port_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and parameter limits for the data-RAM port arbiter
package mem_arb_pkg;
    typedef enum logic {IDLE, RD_WAIT} state_e;
    typedef enum logic {OWN_P0, OWN_P1} owner_e;
    localparam int RD_LAT_MIN     = 1;
    localparam int RD_LAT_MAX     = 7;
    localparam int STARVE_MIN     = 1;
    localparam int STARVE_MAX_LIM = 15;
    localparam int LAT_W          = 3;
    localparam int STARVE_W       = 4;
endpackage

// File: rtl/mem_arb_select.sv
// mem_arb_select: port priority with a saturating port-1 starvation counter
module mem_arb_select
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic       clockCPU,
    input  logic       reset,
    input  logic       en_i,
    input  logic       p0_req_i,
    input  logic       p1_req_i,
    output owner_e     sel_o,
    output logic [1:0] gnt_o
);
    localparam logic [STARVE_W-1:0] LIM = STARVE_W'(STARVE_MAX);
    logic [STARVE_W-1:0] starve_q, starve_d;
    always_comb begin
        sel_o    = (p1_req_i && (starve_q == LIM || !p0_req_i)) ? OWN_P1 : OWN_P0;
        gnt_o    = en_i ? {p1_req_i && sel_o == OWN_P1, p0_req_i && sel_o == OWN_P0} : 2'b00;
        starve_d = (!p1_req_i || gnt_o[1]) ? '0 : (starve_q == LIM ? starve_q : starve_q + 1'b1);
    end
    always_ff @(posedge clockCPU or negedge reset) begin
        if (!reset) starve_q <= '0;
        else        starve_q <= starve_d;
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single-port data RAM between the MEM stage and a secondary master.
// Define MEM_ARB_STATS_EN to add saturating grant/conflict counters.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clockCPU,
    input  logic              reset,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_stall,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q,
    output logic              busy
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [15:0]       stat_gnt0,
    output logic [15:0]       stat_gnt1,
    output logic [15:0]       stat_conflict
`endif
);
    if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_lat
        $error("mem_port_arbiter: RD_LAT out of range");
    end
    if (STARVE_MAX < STARVE_MIN || STARVE_MAX > STARVE_MAX_LIM) begin : g_bad_starve
        $error("mem_port_arbiter: STARVE_MAX out of range");
    end

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d, sel;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d, sel_addr;
    logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d, p1_rdata_q, p1_rdata_d, sel_wdata;
    logic              p0_rvalid_q, p0_rvalid_d, p1_rvalid_q, p1_rvalid_d;
    logic [1:0]        gnt;
    logic              idle, any_gnt, sel_we, rd_done;

    assign idle = state_q == IDLE;

    mem_arb_select #(.STARVE_MAX(STARVE_MAX)) u_select (
        .clockCPU (clockCPU),
        .reset    (reset),
        .en_i     (idle & reset),
        .p0_req_i (p0_req),
        .p1_req_i (p1_req),
        .sel_o    (sel),
        .gnt_o    (gnt)
    );

    always_comb begin
        any_gnt   = |gnt;
        sel_we    = sel == OWN_P1 ? p1_we    : p0_we;
        sel_addr  = sel == OWN_P1 ? p1_addr  : p0_addr;
        sel_wdata = sel == OWN_P1 ? p1_wdata : p0_wdata;
        rd_done   = !idle && lat_q == LAT_W'(1);
        p0_gnt    = gnt[0];
        p1_gnt    = gnt[1];
        mem_wren  = any_gnt & sel_we;
        mem_addr  = idle ? (any_gnt ? sel_addr : '0) : raddr_q;
        mem_wdata = any_gnt ? sel_wdata : '0;
        busy      = !idle;
        // A port-0 read stalls from its grant cycle through the rvalid cycle.
        p0_stall  = reset & ((p0_req & ~gnt[0]) | (gnt[0] & ~p0_we) | (!idle && owner_q == OWN_P0) | p0_rvalid_q);
        state_d   = state_q;
        owner_d   = owner_q;
        lat_d     = lat_q;
        raddr_d   = raddr_q;
        if (idle && any_gnt && !sel_we) begin
            state_d = RD_WAIT;
            owner_d = sel;
            lat_d   = LAT_W'(RD_LAT);
            raddr_d = sel_addr;
        end else if (!idle) begin
            lat_d = lat_q - 1'b1;
            if (rd_done) state_d = IDLE;
        end
        p0_rvalid_d = rd_done && owner_q == OWN_P0;
        p1_rvalid_d = rd_done && owner_q == OWN_P1;
        p0_rdata_d  = p0_rvalid_d ? mem_q : p0_rdata_q;
        p1_rdata_d  = p1_rvalid_d ? mem_q : p1_rdata_q;
    end

    always_ff @(posedge clockCPU or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            owner_q     <= OWN_P0;
            lat_q       <= '0;
            raddr_q     <= '0;
            p0_rdata_q  <= '0;
            p1_rdata_q  <= '0;
            p0_rvalid_q <= 1'b0;
            p1_rvalid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            lat_q       <= lat_d;
            raddr_q     <= raddr_d;
            p0_rdata_q  <= p0_rdata_d;
            p1_rdata_q  <= p1_rdata_d;
            p0_rvalid_q <= p0_rvalid_d;
            p1_rvalid_q <= p1_rvalid_d;
        end
    end

    assign p0_rvalid = p0_rvalid_q;
    assign p1_rvalid = p1_rvalid_q;
    assign p0_rdata  = p0_rdata_q;
    assign p1_rdata  = p1_rdata_q;

`ifdef MEM_ARB_STATS_EN
    logic [15:0] gnt0_q, gnt1_q, conf_q;
    always_ff @(posedge clockCPU or negedge reset) begin
        if (!reset) begin
            gnt0_q <= '0;
            gnt1_q <= '0;
            conf_q <= '0;
        end else begin
            if (gnt[0] && gnt0_q != 16'hFFFF) gnt0_q <= gnt0_q + 1'b1;
            if (gnt[1] && gnt1_q != 16'hFFFF) gnt1_q <= gnt1_q + 1'b1;
            if (idle && p0_req && p1_req && conf_q != 16'hFFFF) conf_q <= conf_q + 1'b1;
        end
    end
    assign stat_gnt0     = gnt0_q;
    assign stat_gnt1     = gnt1_q;
    assign stat_conflict = conf_q;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of the RAM port arbiter at RD_LAT=1 and RD_LAT=3
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
    logic [9:0]  p0_addr = '0, p1_addr = '0;
    logic [31:0] p0_wdata = '0, p1_wdata = '0;

    logic        u1_p0_gnt, u1_p0_rvalid, u1_p0_stall, u1_p1_gnt, u1_p1_rvalid, u1_mem_wren, u1_busy;
    logic [31:0] u1_p0_rdata, u1_p1_rdata, u1_mem_wdata, u1_mem_q;
    logic [9:0]  u1_mem_addr;
    logic        u3_p0_gnt, u3_p0_rvalid, u3_p0_stall, u3_p1_gnt, u3_p1_rvalid, u3_mem_wren, u3_busy;
    logic [31:0] u3_p0_rdata, u3_p1_rdata, u3_mem_wdata;
    logic [9:0]  u3_mem_addr;
`ifdef MEM_ARB_STATS_EN
    logic [15:0] u1_sg0, u1_sg1, u1_sc, u3_sg0, u3_sg1, u3_sc;
`endif

    logic [31:0] ram1 [0:1023];
    logic [31:0] ram3 [0:1023];
    logic [31:0] q3a, q3b, q3c;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.RD_LAT(1), .STARVE_MAX(4)) u1 (
        .clockCPU(clk), .reset(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(u1_p0_gnt), .p0_rvalid(u1_p0_rvalid), .p0_rdata(u1_p0_rdata), .p0_stall(u1_p0_stall),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(u1_p1_gnt), .p1_rvalid(u1_p1_rvalid), .p1_rdata(u1_p1_rdata),
        .mem_addr(u1_mem_addr), .mem_wdata(u1_mem_wdata), .mem_wren(u1_mem_wren),
        .mem_q(u1_mem_q), .busy(u1_busy)
`ifdef MEM_ARB_STATS_EN
        , .stat_gnt0(u1_sg0), .stat_gnt1(u1_sg1), .stat_conflict(u1_sc)
`endif
    );

    mem_port_arbiter #(.RD_LAT(3), .STARVE_MAX(4)) u3 (
        .clockCPU(clk), .reset(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(u3_p0_gnt), .p0_rvalid(u3_p0_rvalid), .p0_rdata(u3_p0_rdata), .p0_stall(u3_p0_stall),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(u3_p1_gnt), .p1_rvalid(u3_p1_rvalid), .p1_rdata(u3_p1_rdata),
        .mem_addr(u3_mem_addr), .mem_wdata(u3_mem_wdata), .mem_wren(u3_mem_wren),
        .mem_q(q3c), .busy(u3_busy)
`ifdef MEM_ARB_STATS_EN
        , .stat_gnt0(u3_sg0), .stat_gnt1(u3_sg1), .stat_conflict(u3_sc)
`endif
    );

    // Synchronous RAM models; preload happens while reset is held.
    always @(posedge clk) begin
        if (!rst_n) begin
            ram1[16] <= 32'hDEADBEEF;
            ram3[64] <= 32'hA1A1A1A1;
            ram3[65] <= 32'hB2B2B2B2;
        end else begin
            if (u1_mem_wren) ram1[u1_mem_addr] <= u1_mem_wdata;
            if (u3_mem_wren) ram3[u3_mem_addr] <= u3_mem_wdata;
        end
        u1_mem_q <= ram1[u1_mem_addr];
        q3a      <= ram3[u3_mem_addr];
        q3b      <= q3a;
        q3c      <= q3b;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        // reset state, with a pending request that must be ignored
        tick();
        p0_req = 1'b1; p0_addr = 10'h010;
        #2;
        chk("rst_gnt",   u1_p0_gnt, 0);
        chk("rst_stall", u1_p0_stall, 0);
        chk("rst_busy",  u1_busy, 0);
        chk("rst_addr",  u1_mem_addr, 0);
        chk("rst_wren",  u1_mem_wren, 0);
        chk("rst_rdata", u1_p0_rdata, 0);
        p0_req = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // p0 read, RD_LAT=1
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 10'h010;
        #2;
        chk("rd0_gnt",   u1_p0_gnt, 1);
        chk("rd0_stall", u1_p0_stall, 1);
        chk("rd0_addr",  u1_mem_addr, 10'h010);
        chk("rd0_busy",  u1_busy, 0);
        tick();
        p0_req = 1'b0;
        #2;
        chk("rd1_busy",  u1_busy, 1);
        chk("rd1_stall", u1_p0_stall, 1);
        chk("rd1_gnt",   u1_p0_gnt, 0);
        chk("rd1_addr",  u1_mem_addr, 10'h010);
        chk("rd1_rv",    u1_p0_rvalid, 0);
        tick();
        #2;
        chk("rd2_rv",    u1_p0_rvalid, 1);
        chk("rd2_data",  u1_p0_rdata, 32'hDEADBEEF);
        chk("rd2_stall", u1_p0_stall, 1);
        chk("rd2_busy",  u1_busy, 0);
        tick();
        #2;
        chk("rd3_rv",    u1_p0_rvalid, 0);
        chk("rd3_stall", u1_p0_stall, 0);
        chk("rd3_hold",  u1_p0_rdata, 32'hDEADBEEF);
        tick();

        // p0 write then p1 read of the same word
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 10'h020; p0_wdata = 32'h12345678;
        #2;
        chk("wr_gnt",   u1_p0_gnt, 1);
        chk("wr_wren",  u1_mem_wren, 1);
        chk("wr_addr",  u1_mem_addr, 10'h020);
        chk("wr_data",  u1_mem_wdata, 32'h12345678);
        chk("wr_stall", u1_p0_stall, 0);
        tick();
        p0_req = 1'b0; p0_we = 1'b0;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 10'h020;
        #2;
        chk("p1rd_gnt",  u1_p1_gnt, 1);
        chk("p1rd_wren", u1_mem_wren, 0);
        tick();
        p1_req = 1'b0;
        #2;
        chk("p1rd_busy",  u1_busy, 1);
        chk("p1rd_wren1", u1_mem_wren, 0);
        chk("p1rd_stall", u1_p0_stall, 0);
        tick();
        #2;
        chk("p1rd_rv",   u1_p1_rvalid, 1);
        chk("p1rd_data", u1_p1_rdata, 32'h12345678);
        chk("p1rd_rv0",  u1_p0_rvalid, 0);
        tick();
        #2;
        chk("p1rd_rvoff", u1_p1_rvalid, 0);
        tick();

        // starvation: both request writes continuously
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 10'h030; p0_wdata = 32'h00000030;
        p1_req = 1'b1; p1_we = 1'b1; p1_addr = 10'h031; p1_wdata = 32'h00000031;
        for (int i = 0; i < 5; i++) begin
            #2;
            chk($sformatf("stv%0d_g0", i), u1_p0_gnt, i < 4);
            chk($sformatf("stv%0d_g1", i), u1_p1_gnt, i == 4);
            tick();
        end
        p1_req = 1'b0;
        #2;
        chk("stv_after_g0", u1_p0_gnt, 1);
        tick();
        p0_req = 1'b0;
        tick();

        // check the forced-grant cycle's stall and address directly
        do_reset();
        p0_req = 1'b1; p1_req = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        #2;
        chk("stv4_stall", u1_p0_stall, 1);
        chk("stv4_addr",  u1_mem_addr, 10'h031);
        p0_req = 1'b0; p1_req = 1'b0;
        tick();

        // simultaneous request once
        do_reset();
        p0_req = 1'b1; p1_req = 1'b1;
        #2;
        chk("sim_g0", u1_p0_gnt, 1);
        chk("sim_g1", u1_p1_gnt, 0);
        tick();
        p0_req = 1'b0;
        #2;
        chk("sim_g1b", u1_p1_gnt, 1);
        tick();
        p1_req = 1'b0;
`ifdef MEM_ARB_STATS_EN
        #2;
        chk("stat_conf", u1_sc, 1);
        chk("stat_g0",   u1_sg0, 1);
        chk("stat_g1",   u1_sg1, 1);
`endif
        tick();

        // reset during RD_WAIT
        p0_we = 1'b0;
        p0_req = 1'b1; p0_addr = 10'h010;
        tick();
        p0_req = 1'b0;
        #2;
        chk("abort_busy", u1_busy, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy0",  u1_busy, 0);
        chk("abort_stall",  u1_p0_stall, 0);
        chk("abort_addr",   u1_mem_addr, 0);
        chk("abort_rdata",  u1_p0_rdata, 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #2;
            chk($sformatf("abort_rv%0d", i), u1_p0_rvalid, 0);
            tick();
        end
        p0_req = 1'b1; p0_addr = 10'h020;
        #2;
        chk("post_gnt", u1_p0_gnt, 1);
        tick();
        p0_req = 1'b0;
        tick();
        #2;
        chk("post_rv",   u1_p0_rvalid, 1);
        chk("post_data", u1_p0_rdata, 32'h12345678);
        tick();

        // RD_LAT=3 back-to-back p0 reads
        do_reset();
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 10'h040;
        #2;
        chk("l3_gnt0", u3_p0_gnt, 1);
        tick();
        p0_addr = 10'h041;
        for (int i = 1; i < 4; i++) begin
            #2;
            chk($sformatf("l3_c%0d_gnt", i), u3_p0_gnt, 0);
            chk($sformatf("l3_c%0d_rv", i),  u3_p0_rvalid, 0);
            chk($sformatf("l3_c%0d_stl", i), u3_p0_stall, 1);
            tick();
        end
        #2;
        chk("l3_c4_rv",   u3_p0_rvalid, 1);
        chk("l3_c4_data", u3_p0_rdata, 32'hA1A1A1A1);
        chk("l3_c4_gnt",  u3_p0_gnt, 1);
        tick();
        p0_req = 1'b0;
        for (int i = 5; i < 8; i++) begin
            #2;
            chk($sformatf("l3_c%0d_rv", i),   u3_p0_rvalid, 0);
            chk($sformatf("l3_c%0d_busy", i), u3_busy, 1);
            tick();
        end
        #2;
        chk("l3_c8_rv",   u3_p0_rvalid, 1);
        chk("l3_c8_data", u3_p0_rdata, 32'hB2B2B2B2);
        tick();
        #2;
        chk("l3_c9_rv",    u3_p0_rvalid, 0);
        chk("l3_c9_stall", u3_p0_stall, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
